// File: rtl/param_memory.sv
// Single-port-array memory with a 1-cycle instruction read port and a wait-stated data port.
// Define MEM_FORWARD_EN to forward committing write data to a colliding instruction read.
module param_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_data,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    commit;
  logic                    enter_access;
  logic [ADDR_WIDTH-1:0]   access_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (d_req) begin
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_LOAD != 4'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    d_busy = (state != S_IDLE);
    d_ack  = (state == S_ACCESS);
  end

  // A request accepted straight into ACCESS has not been latched yet, so read from the live address.
  assign enter_access = (state_next == S_ACCESS) && (state != S_ACCESS);
  assign access_addr  = (state == S_IDLE) ? d_addr : addr_q;
  assign commit       = (state == S_ACCESS) && we_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && d_req) begin
      we_q    <= d_we;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_rdata <= '0;
    end else if (enter_access) begin
      d_rdata <= mem[access_addr];
    end
  end

  // The array has no reset so its contents survive reset; an aborted write never reaches ACCESS.
  always_ff @(posedge clock) begin
    if (commit) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_data <= '0;
    end else begin
`ifdef MEM_FORWARD_EN
      if (commit && (i_addr == addr_q)) begin
        i_data <= wdata_q;
      end else begin
        i_data <= mem[i_addr];
      end
`else
      i_data <= mem[i_addr];
`endif
    end
  end

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory: two instances (WAIT_STATES=2 and 0) with decoupled ack monitors.
module tb_param_memory;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          chk;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  i_addr_a, i_addr_b;
  logic [15:0] i_data_a, i_data_b;
  logic        d_req_a, d_we_a, d_req_b, d_we_b;
  logic [7:0]  d_addr_a, d_addr_b;
  logic [15:0] d_wdata_a, d_wdata_b, d_rdata_a, d_rdata_b;
  logic        d_ack_a, d_ack_b, d_busy_a, d_busy_b;

  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(WS_A)) u_dut_a (
    .clock(clock), .reset(reset), .i_addr(i_addr_a), .i_data(i_data_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_rdata(d_rdata_a), .d_ack(d_ack_a), .d_busy(d_busy_a)
  );

  param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(WS_B)) u_dut_b (
    .clock(clock), .reset(reset), .i_addr(i_addr_b), .i_data(i_data_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_rdata(d_rdata_b), .d_ack(d_ack_b), .d_busy(d_busy_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitors pop one expectation per acknowledge; a late or spurious ack is an error.
  always @(negedge clock) begin
    if (d_ack_a === 1'b1) begin
      if (qa.size() == 0) begin
        check("ack_a_unexpected", 32'(d_ack_a), 32'd0);
      end else begin
        ea = qa.pop_front();
        check("ack_a_cycle", 32'(edge_cnt), 32'(ea.cyc));
        if (ea.chk) check("rdata_a", 32'(d_rdata_a), 32'(ea.data));
      end
    end else if (qa.size() > 0 && edge_cnt > qa[0].cyc) begin
      ea = qa.pop_front();
      check("ack_a_missing", 32'(d_ack_a), 32'd1);
    end
  end

  always @(negedge clock) begin
    if (d_ack_b === 1'b1) begin
      if (qb.size() == 0) begin
        check("ack_b_unexpected", 32'(d_ack_b), 32'd0);
      end else begin
        eb = qb.pop_front();
        check("ack_b_cycle", 32'(edge_cnt), 32'(eb.cyc));
        if (eb.chk) check("rdata_b", 32'(d_rdata_b), 32'(eb.data));
      end
    end else if (qb.size() > 0 && edge_cnt > qb[0].cyc) begin
      eb = qb.pop_front();
      check("ack_b_missing", 32'(d_ack_b), 32'd1);
    end
  end

  // Issue one transfer, scramble the request fields right after acceptance, and track d_busy.
  task automatic issue(input bit sel, input bit we, input logic [7:0] addr,
                       input logic [15:0] wdata, input bit chk, input logic [15:0] exp);
    int   ws;
    int   t;
    exp_t e;
    ws = sel ? WS_B : WS_A;
    @(negedge clock);
    t = edge_cnt + 1;
    e.cyc  = t + ws;
    e.data = exp;
    e.chk  = chk;
    if (sel) begin
      d_req_b = 1'b1; d_we_b = we; d_addr_b = addr; d_wdata_b = wdata;
      qb.push_back(e);
    end else begin
      d_req_a = 1'b1; d_we_a = we; d_addr_a = addr; d_wdata_a = wdata;
      qa.push_back(e);
    end
    for (int k = 0; k <= ws + 1; k++) begin
      @(negedge clock);
      if (k == 0) begin
        if (sel) begin
          d_req_b = 1'b0; d_we_b = ~we; d_addr_b = addr + 8'd1; d_wdata_b = ~wdata;
        end else begin
          d_req_a = 1'b0; d_we_a = ~we; d_addr_a = addr + 8'd1; d_wdata_a = ~wdata;
        end
      end
      if (sel) check("busy_b", 32'(d_busy_b), 32'(k <= ws));
      else     check("busy_a", 32'(d_busy_a), 32'(k <= ws));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ack_a", 32'(d_ack_a), 32'd0);
    check("rst_busy_a", 32'(d_busy_a), 32'd0);
    check("rst_rdata_a", 32'(d_rdata_a), 32'd0);
    check("rst_idata_a", 32'(i_data_a), 32'd0);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    i_addr_a = 8'h00; i_addr_b = 8'h00;
    d_req_a = 1'b0; d_we_a = 1'b0; d_addr_a = 8'h00; d_wdata_a = 16'h0000;
    d_req_b = 1'b0; d_we_b = 1'b0; d_addr_b = 8'h00; d_wdata_b = 16'h0000;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    check("rst_ack_b", 32'(d_ack_b), 32'd0);
    check("rst_busy_b", 32'(d_busy_b), 32'd0);
    check("rst_rdata_b", 32'(d_rdata_b), 32'd0);
    check("rst_idata_b", 32'(i_data_b), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Wait-stated write then instruction-port readback.
    issue(1'b0, 1'b1, 8'h10, 16'h00FF, 1'b0, 16'h0000);
    i_addr_a = 8'h10;
    @(negedge clock);
    check("idata_after_write", 32'(i_data_a), 32'h00FF);

    // Zero-wait instance: write then read back on the data port.
    issue(1'b1, 1'b1, 8'h10, 16'h00FF, 1'b0, 16'h0000);
    issue(1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 16'h00FF);

    // Read-during-write collision on the instruction port.
    issue(1'b0, 1'b1, 8'h20, 16'h1111, 1'b0, 16'h0000);
    i_addr_a = 8'h20;
    issue(1'b0, 1'b1, 8'h20, 16'hABCD, 1'b1, 16'h1111);
`ifdef MEM_FORWARD_EN
    check("idata_collision", 32'(i_data_a), 32'hABCD);
`else
    check("idata_collision", 32'(i_data_a), 32'h1111);
`endif
    @(negedge clock);
    check("idata_after_collision", 32'(i_data_a), 32'hABCD);
    issue(1'b0, 1'b0, 8'h20, 16'h0000, 1'b1, 16'hABCD);

    // Fields changing after acceptance must not redirect the transfer.
    issue(1'b0, 1'b1, 8'h40, 16'h4040, 1'b0, 16'h0000);
    issue(1'b0, 1'b1, 8'h41, 16'h4141, 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 8'h40, 16'h0000, 1'b1, 16'h4040);
    issue(1'b0, 1'b0, 8'h40, 16'h0000, 1'b1, 16'h4040);
    issue(1'b0, 1'b0, 8'h41, 16'h0000, 1'b1, 16'h4141);
    issue(1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000);

    // Reset during WAIT aborts a write without touching the array.
    issue(1'b0, 1'b1, 8'h30, 16'h5555, 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 8'h10, 16'h0000, 1'b1, 16'h00FF);
    i_addr_a = 8'h10;
    @(negedge clock);
    d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 8'h30; d_wdata_a = 16'h1234;
    @(negedge clock);
    d_req_a = 1'b0;
    check("busy_before_abort", 32'(d_busy_a), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #1 reset = 1'b0;
    issue(1'b0, 1'b0, 8'h30, 16'h0000, 1'b1, 16'h5555);

    // Continuous request: ack every WS_A+2 cycles with one idle cycle between transfers.
    @(negedge clock);
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 8'h10;
    t = edge_cnt + 1;
    for (int n = 0; n < 3; n++) qa.push_back('{t + WS_A + n * (WS_A + 2), 16'h00FF, 1'b1});
    for (int k = 0; k <= 3 * (WS_A + 2) - 1; k++) begin
      @(negedge clock);
      if (k == 2 * (WS_A + 2)) d_req_a = 1'b0;
      check("busy_b2b", 32'(d_busy_a), 32'((k % (WS_A + 2)) != (WS_A + 1)));
    end

    repeat (4) @(negedge clock);
    check("pending_a", 32'(qa.size()), 32'd0);
    check("pending_b", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, address width in bits; depth is 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, range 0..15, extra cycles inserted before each data-port acknowledge.
REQ-004 The block SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port i_addr  input  ADDR_WIDTH  instruction-port read address.
REQ-007 The block SHALL have port i_data  output  DATA_WIDTH  registered instruction-port read data.
REQ-008 The block SHALL have port d_req  input  1  data-port request, sampled only in IDLE.
REQ-009 The block SHALL have port d_we  input  1  data-port direction, 0 read, 1 write, latched with d_req.
REQ-010 The block SHALL have port d_addr  input  ADDR_WIDTH  data-port address, latched with d_req.
REQ-011 The block SHALL have port d_wdata  input  DATA_WIDTH  data-port write data, latched with d_req.
REQ-012 The block SHALL have port d_rdata  output  DATA_WIDTH  data-port read data, valid while d_ack is high.
REQ-013 The block SHALL have port d_ack  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port d_busy  output  1  high whenever the data-port FSM is not IDLE.

Function
REQ-015 Storage SHALL be a 2^ADDR_WIDTH x DATA_WIDTH array; every address in 0..2^ADDR_WIDTH-1 is valid, with no wrap or aliasing.
REQ-016 On every rising edge, i_data SHALL load the array word at i_addr (1-cycle latency, independent of the data port).
REQ-017 Data-port FSM states SHALL be IDLE, WAIT and ACCESS.
REQ-018 In IDLE with d_req=1 at an edge, the FSM SHALL latch d_we/d_addr/d_wdata, load a wait counter with WAIT_STATES, and go to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-019 In WAIT the counter SHALL decrement each edge; the FSM SHALL move to ACCESS on the edge where the counter reaches 0.
REQ-020 ACCESS SHALL last exactly one cycle with d_ack=1, then return to IDLE unconditionally.
REQ-021 For a request sampled at edge T, d_ack SHALL be high during the cycle after edge T+WAIT_STATES.
REQ-022 On entry to ACCESS, d_rdata SHALL load the array word at the latched address (for writes, the pre-write contents).
REQ-023 A latched write SHALL commit to the array at the edge leaving ACCESS.
REQ-024 d_rdata SHALL hold its value until the next ACCESS entry.
REQ-025 d_req SHALL be ignored in WAIT and ACCESS; back-to-back transfers need d_req high in the cycle after d_ack, with one IDLE cycle between ACKs minimum.
REQ-026 Changes to d_we/d_addr/d_wdata after acceptance SHALL have no effect on the transfer in progress.
REQ-027 When i_addr equals the committing write address at the commit edge, i_data SHALL follow REQ-035/REQ-036.

Reset
REQ-028 Asserting reset SHALL immediately force the FSM to IDLE, the wait counter to 0, and d_ack, d_busy, d_rdata, i_data to 0.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 Reset during WAIT or ACCESS SHALL abort the transfer; an aborted write SHALL NOT modify the array.
REQ-031 After reset deasserts, the first rising edge SHALL sample d_req normally.

Configuration
REQ-032 Macro MEM_FORWARD_EN SHALL select instruction-port read-during-write behaviour.
REQ-033 With MEM_FORWARD_EN defined, a colliding i_data read SHALL return the new write data.
REQ-034 Without MEM_FORWARD_EN, a colliding i_data read SHALL return the old array contents.
REQ-035 Defined forwarding: i_data <= latched d_wdata at the commit edge when addresses match.
REQ-036 Undefined forwarding: i_data <= old array word at the commit edge when addresses match.

Verification
REQ-037 WAIT_STATES=2: write 16'h00FF to address 0x10 (req at edge 0) -> d_busy high cycles 1-3, d_ack high cycle 3 only; then i_addr=0x10 -> i_data=16'h00FF one edge later.
REQ-038 WAIT_STATES=0: read 0x10 after REQ-037 -> d_ack in cycle after request edge, d_rdata=16'h00FF.
REQ-039 Write 16'hABCD to 0x20 while i_addr=0x20 at commit edge -> i_data=16'hABCD with MEM_FORWARD_EN, old word without it.
REQ-040 WAIT_STATES=3: assert reset during WAIT of a write of 16'h1234 to 0x30 -> outputs 0 immediately, no d_ack, address 0x30 unchanged.
REQ-041 Hold d_req high continuously with WAIT_STATES=1 -> d_ack pulses every 3 cycles, d_busy low exactly one cycle between transfers.
REQ-042 Change d_addr from 0x40 to 0x41 one cycle after acceptance of a read -> d_rdata returns the word at 0x40.
